tlk2711_rx_cmd: RTL and testbench

TLK2711_RX_CMD -- requirements
Module: tlk2711_rx_cmd

---
 rtl/tlk2711_rx_cmd_if.sv | 25 ++
 rtl/tlk2711_rx_cmd.sv | 193 +++++++++++++++++++
 tb/tb_tlk2711_rx_cmd.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlk2711_rx_cmd_if.sv
// DMA write-command handshake between the TLK2711 receive command generator
// and the DMA engine; the master issues commands, the slave accepts them.
interface tlk2711_rx_cmd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DLEN_WIDTH = 16
);
    logic                             o_wr_cmd_req;
    logic                             i_wr_cmd_ack;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0] o_wr_cmd_data;
    logic                             i_dma_wr_last;

    modport master (
        output o_wr_cmd_req,
        output o_wr_cmd_data,
        input  i_wr_cmd_ack,
        input  i_dma_wr_last
    );

    modport slave (
        input  o_wr_cmd_req,
        input  o_wr_cmd_data,
        output i_wr_cmd_ack,
        output i_dma_wr_last
    );
endinterface

// File: rtl/tlk2711_rx_cmd.sv
// Turns completed TLK2711 receive frames into DMA write commands at consecutive addresses.
// Define TLK2711_RX_RING_WRAP_EN to restart at the base address after the last frame.
module tlk2711_rx_cmd #(
    parameter int ADDR_WIDTH = 32,
    parameter int DLEN_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_soft_rst,
    input  logic                  i_rx_start,
    input  logic [ADDR_WIDTH-1:0] i_rx_base_addr,
    input  logic [15:0]           i_rx_frame_num,
    input  logic                  i_rx_frame_valid,
    input  logic [15:0]           i_rx_frame_len,
    tlk2711_rx_cmd_if.master      wr_if,
    output logic [15:0]           o_rx_frame_cnt,
    output logic                  o_rx_done,
    output logic                  o_overflow
);

    // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap on their own.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e                           state_q, state_d;
    logic                             rx_start_q, rx_start_d;
    logic                             start_pulse_q, start_pulse_d;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic [15:0]                      frame_cnt_q, frame_cnt_d;
    logic                             done_q, done_d;
    logic                             overflow_q, overflow_d;
    logic                             req_q, req_d;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0] data_q, data_d;
    logic [DLEN_WIDTH-1:0]            cmd_len_q, cmd_len_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 fifo_cnt_q, fifo_cnt_d;
    logic [DLEN_WIDTH-1:0]            fifo_mem [FIFO_DEPTH];

    logic                             flush;
    logic                             push_req;
    logic                             push_en;
    logic                             pop_en;
    logic                             fifo_full;
    logic [16:0]                      len_rnd;
    logic [DLEN_WIDTH-1:0]            head_len;
    logic [15:0]                      num_eff;

    assign flush     = i_soft_rst || start_pulse_q;
    assign fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign head_len  = fifo_mem[rd_ptr_q];
    assign num_eff   = (i_rx_frame_num == 16'd0) ? 16'd1 : i_rx_frame_num;
    // Round up to the next 8-byte multiple; 17 bits so 0xFFF9..0xFFFF cannot wrap.
    assign len_rnd   = {1'b0, i_rx_frame_len & 16'hFFF8}
                     + {13'd0, |i_rx_frame_len[2:0], 3'b000};

    assign push_req  = i_rx_frame_valid && (i_rx_frame_len != 16'd0);
    assign push_en   = push_req && !flush && !fifo_full && (state_q != ST_DONE);
    assign pop_en    = (state_q == ST_ISSUE) && req_q && wr_if.i_wr_cmd_ack && !flush;

    // NOTE: every variable gets its default before the case so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        rx_start_d    = i_rx_start;
        start_pulse_d = i_rx_start && !rx_start_q;
        addr_d        = addr_q;
        frame_cnt_d   = frame_cnt_q;
`ifdef TLK2711_RX_RING_WRAP_EN
        done_d        = 1'b0;
`else
        done_d        = done_q;
`endif
        overflow_d    = overflow_q;
        req_d         = req_q;
        data_d        = data_q;
        cmd_len_d     = cmd_len_q;
        wr_ptr_d      = wr_ptr_q + PTR_W'(push_en);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop_en);
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);

        if (push_req && !push_en && !flush) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fifo_cnt_q != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // First ISSUE cycle latches the command; it then stays frozen until ack.
                if (!req_q) begin
                    req_d     = 1'b1;
                    data_d    = {addr_q, head_len};
                    cmd_len_d = head_len;
                end else if (wr_if.i_wr_cmd_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wr_if.i_dma_wr_last) begin
                    addr_d      = addr_q + ADDR_WIDTH'(cmd_len_q);
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                    if (frame_cnt_d >= num_eff) begin
                        done_d = 1'b1;
`ifdef TLK2711_RX_RING_WRAP_EN
                        addr_d      = i_rx_base_addr;
                        frame_cnt_d = 16'd0;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Soft reset and a fresh start pulse override everything above.
        if (flush) begin
            state_d     = ST_IDLE;
            addr_d      = i_rx_base_addr;
            frame_cnt_d = 16'd0;
            done_d      = 1'b0;
            overflow_d  = 1'b0;
            req_d       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rx_start_q    <= 1'b0;
            start_pulse_q <= 1'b0;
            addr_q        <= '0;
            frame_cnt_q   <= 16'd0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            req_q         <= 1'b0;
            data_q        <= '0;
            cmd_len_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rx_start_q    <= rx_start_d;
            start_pulse_q <= start_pulse_d;
            addr_q        <= addr_d;
            frame_cnt_q   <= frame_cnt_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            req_q         <= req_d;
            data_q        <= data_d;
            cmd_len_q     <= cmd_len_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // NOTE: storage is not reset; entries are only read after being written behind the pointers.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr_q] <= len_rnd[DLEN_WIDTH-1:0];
        end
    end

    assign wr_if.o_wr_cmd_req  = req_q;
    assign wr_if.o_wr_cmd_data = data_q;
    assign o_rx_frame_cnt      = frame_cnt_q;
    assign o_rx_done           = done_q;
    assign o_overflow          = overflow_q;

endmodule

// File: tb/tb_tlk2711_rx_cmd.sv
// Directed self-checking bench for tlk2711_rx_cmd (default 32-bit address, 16-bit length, depth 4).
// Builds with or without TLK2711_RX_RING_WRAP_EN; expectations follow the macro.
module tb_tlk2711_rx_cmd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_soft_rst;
    logic        i_rx_start;
    logic [31:0] i_rx_base_addr;
    logic [15:0] i_rx_frame_num;
    logic        i_rx_frame_valid;
    logic [15:0] i_rx_frame_len;
    logic [15:0] o_rx_frame_cnt;
    logic        o_rx_done;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;

    tlk2711_rx_cmd_if #(.ADDR_WIDTH(32), .DLEN_WIDTH(16)) wr_if ();

    tlk2711_rx_cmd #(.ADDR_WIDTH(32), .DLEN_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_soft_rst       (i_soft_rst),
        .i_rx_start       (i_rx_start),
        .i_rx_base_addr   (i_rx_base_addr),
        .i_rx_frame_num   (i_rx_frame_num),
        .i_rx_frame_valid (i_rx_frame_valid),
        .i_rx_frame_len   (i_rx_frame_len),
        .wr_if            (wr_if),
        .o_rx_frame_cnt   (o_rx_frame_cnt),
        .o_rx_done        (o_rx_done),
        .o_overflow       (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [31:0] base, input logic [15:0] num);
        i_rx_base_addr = base;
        i_rx_frame_num = num;
        i_rx_start     = 1'b1;
        tick();
        tick();
        i_rx_start     = 1'b0;
        tick();
    endtask

    task automatic push(input logic [15:0] len);
        i_rx_frame_valid = 1'b1;
        i_rx_frame_len   = len;
        tick();
        i_rx_frame_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wr_if.o_wr_cmd_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_req"}, 64'(got), 64'd1);
    endtask

    task automatic pulse_last();
        tick();
        wr_if.i_dma_wr_last = 1'b1;
        tick();
        wr_if.i_dma_wr_last = 1'b0;
    endtask

    // Plays the DMA side for one command: wait, compare, hold off ack, accept, finish.
    task automatic serve(input string tag, input logic [47:0] exp, input int hold,
                         input bit send_last, input bit exp_done);
        int unstable = 0;
        wait_req(tag);
        check({tag, "_data"}, 64'(wr_if.o_wr_cmd_data), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            tick();
            if (wr_if.o_wr_cmd_req !== 1'b1 || wr_if.o_wr_cmd_data !== exp) unstable++;
        end
        if (hold > 0) check({tag, "_stable"}, 64'(unstable), 64'd0);
        wr_if.i_wr_cmd_ack = 1'b1;
        tick();
        wr_if.i_wr_cmd_ack = 1'b0;
        check({tag, "_req_drop"}, 64'(wr_if.o_wr_cmd_req), 64'd0);
        if (send_last) begin
            pulse_last();
            check({tag, "_done"}, 64'(o_rx_done), 64'(exp_done));
        end
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (wr_if.o_wr_cmd_req !== 1'b0) seen++;
        end
        check({tag, "_no_req"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst_n               = 1'b0;
        i_soft_rst          = 1'b0;
        i_rx_start          = 1'b0;
        i_rx_base_addr      = 32'h0;
        i_rx_frame_num      = 16'd0;
        i_rx_frame_valid    = 1'b0;
        i_rx_frame_len      = 16'd0;
        wr_if.i_wr_cmd_ack  = 1'b0;
        wr_if.i_dma_wr_last = 1'b0;
        tick();
        tick();
        check("rst_req",  64'(wr_if.o_wr_cmd_req),  64'd0);
        check("rst_data", 64'(wr_if.o_wr_cmd_data), 64'd0);
        check("rst_cnt",  64'(o_rx_frame_cnt),      64'd0);
        check("rst_done", 64'(o_rx_done),           64'd0);
        check("rst_ovf",  64'(o_overflow),          64'd0);
        rst_n = 1'b1;
        tick();

        // Three-frame session with rounding and address accumulation.
        start_session(32'h1000_0000, 16'd3);
        push(16'd870);
        tick();
        check("lat_edge1_req", 64'(wr_if.o_wr_cmd_req), 64'd0);
        tick();
        check("lat_edge2_req", 64'(wr_if.o_wr_cmd_req), 64'd1);
        push(16'd870);
        push(16'd100);
        serve("s1c1", {32'h1000_0000, 16'd872}, 0, 1'b1, 1'b0);
        check("s1_cnt1", 64'(o_rx_frame_cnt), 64'd1);
        serve("s1c2", {32'h1000_0368, 16'd872}, 0, 1'b1, 1'b0);
        serve("s1c3", {32'h1000_06D0, 16'd104}, 0, 1'b1, 1'b1);
        tick();
`ifdef TLK2711_RX_RING_WRAP_EN
        check("s1_cnt_wrap", 64'(o_rx_frame_cnt), 64'd0);
        check("s1_done_pulse_end", 64'(o_rx_done), 64'd0);
`else
        check("s1_cnt3", 64'(o_rx_frame_cnt), 64'd3);
        check("s1_done_sticky", 64'(o_rx_done), 64'd1);
`endif

        // Soft reset while waiting for the write to finish.
        start_session(32'h2000_0000, 16'd4);
        check("s2_done_clr", 64'(o_rx_done), 64'd0);
        push(16'd64);
        serve("s2c1", {32'h2000_0000, 16'd64}, 0, 1'b0, 1'b0);
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        check("srst_req", 64'(wr_if.o_wr_cmd_req), 64'd0);
        check("srst_cnt", 64'(o_rx_frame_cnt), 64'd0);
        pulse_last();
        tick();
        check("srst_late_last_cnt", 64'(o_rx_frame_cnt), 64'd0);
        expect_idle("srst_empty", 6);
        push(16'd8);
        serve("s2c2", {32'h2000_0000, 16'd8}, 0, 1'b1, 1'b0);
        check("s2_cnt1", 64'(o_rx_frame_cnt), 64'd1);

        // Overflow with ack held back, then in-order drain with a long ack hold.
        start_session(32'h3000_0000, 16'd8);
        for (int i = 0; i < 4; i++) push(16'd64);
        check("ovf_after4", 64'(o_overflow), 64'd0);
        push(16'd64);
        check("ovf_after5", 64'(o_overflow), 64'd1);
        serve("s3c1", {32'h3000_0000, 16'd64}, 10, 1'b1, 1'b0);
        serve("s3c2", {32'h3000_0040, 16'd64}, 0, 1'b1, 1'b0);
        serve("s3c3", {32'h3000_0080, 16'd64}, 0, 1'b1, 1'b0);
        serve("s3c4", {32'h3000_00C0, 16'd64}, 0, 1'b1, 1'b0);
        expect_idle("s3_drained", 6);
        check("ovf_sticky", 64'(o_overflow), 64'd1);
        check("s3_cnt4", 64'(o_rx_frame_cnt), 64'd4);

        // Zero-length frame, and push coinciding with the popping ack.
        start_session(32'h4000_0000, 16'd8);
        check("s4_ovf_clr", 64'(o_overflow), 64'd0);
        push(16'd0);
        expect_idle("zero_len", 5);
        check("zero_len_ovf", 64'(o_overflow), 64'd0);
        push(16'd24);
        wait_req("s4c1");
        check("s4c1_data", 64'(wr_if.o_wr_cmd_data), 64'({32'h4000_0000, 16'd24}));
        i_rx_frame_valid   = 1'b1;
        i_rx_frame_len     = 16'd41;
        wr_if.i_wr_cmd_ack = 1'b1;
        tick();
        i_rx_frame_valid   = 1'b0;
        wr_if.i_wr_cmd_ack = 1'b0;
        check("s4c1_req_drop", 64'(wr_if.o_wr_cmd_req), 64'd0);
        pulse_last();
        serve("s4c2", {32'h4000_0018, 16'd48}, 0, 1'b1, 1'b0);
        expect_idle("s4_empty", 6);
        check("s4_ovf", 64'(o_overflow), 64'd0);
        check("s4_cnt2", 64'(o_rx_frame_cnt), 64'd2);

`ifdef TLK2711_RX_RING_WRAP_EN
        // Ring operation: two-frame session seen twice.
        start_session(32'h5000_0000, 16'd2);
        for (int i = 0; i < 4; i++) push(16'd16);
        serve("r1", {32'h5000_0000, 16'd16}, 0, 1'b1, 1'b0);
        serve("r2", {32'h5000_0010, 16'd16}, 0, 1'b1, 1'b1);
        serve("r3", {32'h5000_0000, 16'd16}, 0, 1'b1, 1'b0);
        serve("r4", {32'h5000_0010, 16'd16}, 0, 1'b1, 1'b1);
        check("ring_cnt", 64'(o_rx_frame_cnt), 64'd0);
`endif

        // Reset in the middle of a handshake abandons the command.
        push(16'd32);
        wait_req("rst_mid");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_req", 64'(wr_if.o_wr_cmd_req), 64'd0);
        check("rst_mid_data", 64'(wr_if.o_wr_cmd_data), 64'd0);
        expect_idle("rst_mid_empty", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
